// File: rtl/beep_scheduler.sv
// beep_scheduler: sequences countdown beeps, the end-of-count alarm and keypad clicks onto one buzzer
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous active-low reset
//   enable       in  countdown running
//   secs         in  remaining seconds
//   sec_tick     in  one-cycle pulse per second
//   click_req    in  one-cycle keypad click request
//   alarm_stop   in  level, silences the alarm
//   tone_en      out buzzer on
//   tone_div     out tone generator divisor, 0 when silent
//   click_ack    out one-cycle pulse when a click starts
//   alarm_active out high while the alarm plays
module beep_scheduler #(
  parameter int DIV_W        = 16,
  parameter int BEEP_CYCLES  = 5_000_000,
  parameter int CLICK_CYCLES = 2_500_000,
  parameter int CLICK_DIV    = 12000,
  parameter int ALARM_SECS   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       secs,
  input  logic             sec_tick,
  input  logic             click_req,
  input  logic             alarm_stop,
  output logic             tone_en,
  output logic [DIV_W-1:0] tone_div,
  output logic             click_ack,
  output logic             alarm_active
);
  localparam int MAXC = BEEP_CYCLES > CLICK_CYCLES ? BEEP_CYCLES : CLICK_CYCLES;
  localparam int DW   = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int AW   = $clog2(ALARM_SECS + 1);
  typedef enum logic [2:0] {IDLE, BEEP, CLICK, ALARM, DONE} state_t;
  state_t           state_q, state_d;
  logic [DW-1:0]    dur_q, dur_d;
  logic [AW-1:0]    asec_q, asec_d, asec_n;
  logic             pend_q, pend_d, ret_q, ret_d;
  logic             tone_en_q, tone_en_d, ack_q, ack_d, alarm_q, alarm_d;
  logic [DIV_W-1:0] div_q, div_d, pitch;
  logic             beep_trig, alarm_trig;
  assign beep_trig  = enable & sec_tick & (secs != 8'd0);
  assign alarm_trig = enable & (secs == 8'd0);
  assign pitch = secs >= 8'd30 ? DIV_W'(17980) :
                 secs >= 8'd10 ? DIV_W'(19200) :
                 secs >= 8'd5  ? DIV_W'(24000) :
                 secs >= 8'd1  ? DIV_W'(28800) : DIV_W'(32000);
  assign asec_n = (sec_tick && asec_q != AW'(ALARM_SECS)) ? asec_q + AW'(1) : asec_q;
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    asec_d  = asec_q;
    pend_d  = pend_q | click_req;
    ret_d   = ret_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && (!enable || secs != 8'd0)) begin
          state_d = IDLE;
        end else if (state_q == IDLE && alarm_trig) begin
          state_d = ALARM;
          asec_d  = '0;
          pend_d  = 1'b0;
        end else if (state_q == IDLE && beep_trig) begin
          state_d = BEEP;
          dur_d   = DW'(BEEP_CYCLES - 1);
        end else if (click_req || pend_q) begin
          // a click started from DONE must return there, not rearm the alarm
          state_d = CLICK;
          dur_d   = DW'(CLICK_CYCLES - 1);
          ack_d   = 1'b1;
          pend_d  = 1'b0;
          ret_d   = state_q == DONE;
        end
      end
      BEEP: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (alarm_trig) begin
          state_d = ALARM;
          asec_d  = '0;
          pend_d  = 1'b0;
        end else if (beep_trig) begin
          dur_d = DW'(BEEP_CYCLES - 1);
        end else if (dur_q == '0) begin
          state_d = IDLE;
        end else begin
          dur_d = dur_q - DW'(1);
        end
      end
      CLICK: begin
        if (alarm_trig && !ret_q) begin
          state_d = ALARM;
          asec_d  = '0;
          pend_d  = 1'b0;
        end else if (beep_trig) begin
          state_d = BEEP;
          dur_d   = DW'(BEEP_CYCLES - 1);
        end else if (dur_q == '0) begin
          state_d = ret_q ? DONE : IDLE;
        end else begin
          dur_d = dur_q - DW'(1);
        end
      end
      ALARM: begin
        pend_d = 1'b0;
        asec_d = asec_n;
        if (!enable) begin
          state_d = IDLE;
        end else if (alarm_stop || asec_n == AW'(ALARM_SECS)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tone_en_d = state_d == BEEP || state_d == CLICK || state_d == ALARM;
    alarm_d   = state_d == ALARM;
    // pitch is latched on the trigger and held for the rest of the beep
    div_d = state_d == BEEP  ? (beep_trig ? pitch : div_q) :
            state_d == CLICK ? DIV_W'(CLICK_DIV) :
            state_d == ALARM ? DIV_W'(32000) : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dur_q     <= '0;
      asec_q    <= '0;
      pend_q    <= 1'b0;
      ret_q     <= 1'b0;
      tone_en_q <= 1'b0;
      div_q     <= '0;
      ack_q     <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      asec_q    <= asec_d;
      pend_q    <= pend_d;
      ret_q     <= ret_d;
      tone_en_q <= tone_en_d;
      div_q     <= div_d;
      ack_q     <= ack_d;
      alarm_q   <= alarm_d;
    end
  end
  assign tone_en      = tone_en_q;
  assign tone_div     = div_q;
  assign click_ack    = ack_q;
  assign alarm_active = alarm_q;
endmodule

// File: tb/tb_beep_scheduler.sv
// tb_beep_scheduler: scoreboard bench for beep_scheduler with short beep/click/alarm lengths
module tb_beep_scheduler;
  logic        clk, reset, enable, sec_tick, click_req, alarm_stop;
  logic [7:0]  secs;
  logic        tone_en, click_ack, alarm_active;
  logic [15:0] tone_div;
  logic [18:0] sb_q[$];
  int          n_chk = 0, n_err = 0;
  beep_scheduler #(.DIV_W(16), .BEEP_CYCLES(4), .CLICK_CYCLES(2), .CLICK_DIV(12000), .ALARM_SECS(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .secs(secs), .sec_tick(sec_tick),
    .click_req(click_req), .alarm_stop(alarm_stop), .tone_en(tone_en), .tone_div(tone_div),
    .click_ack(click_ack), .alarm_active(alarm_active)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got en=%b div=%0d ack=%b al=%b exp en=%b div=%0d ack=%b al=%b", tag,
               got[18], got[17:2], got[1], got[0], exp[18], exp[17:2], exp[1], exp[0]);
    end
  endtask
  task automatic tick(input string tag, input logic en, input int div, input logic ack, input logic al);
    logic [18:0] exp;
    sb_q.push_back({en, 16'(div), ack, al});
    @(negedge clk);
    sec_tick  = 1'b0;
    click_req = 1'b0;
    exp = sb_q.pop_front();
    check(tag, {tone_en, tone_div, click_ack, alarm_active}, exp);
  endtask
  initial begin
    reset = 1'b0; enable = 1'b0; secs = 8'd0; sec_tick = 1'b0; click_req = 1'b0; alarm_stop = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", {tone_en, tone_div, click_ack, alarm_active}, 19'd0);
    reset = 1'b1;
    tick("idle", 0, 0, 0, 0);
    enable = 1'b1; secs = 8'd35; sec_tick = 1'b1;
    repeat (4) tick("beep35", 1, 17980, 0, 0);
    tick("beep35_end", 0, 0, 0, 0);
    tick("idle35", 0, 0, 0, 0);
    secs = 8'd3; sec_tick = 1'b1; click_req = 1'b1;
    repeat (4) tick("beep3", 1, 28800, 0, 0);
    tick("beep3_end", 0, 0, 0, 0);
    tick("pend_ack", 1, 12000, 1, 0);
    tick("pend_click", 1, 12000, 0, 0);
    tick("pend_end", 0, 0, 0, 0);
    secs = 8'd12; click_req = 1'b1;
    tick("click_ack", 1, 12000, 1, 0);
    sec_tick = 1'b1;
    repeat (4) tick("preempt", 1, 19200, 0, 0);
    tick("preempt_end", 0, 0, 0, 0);
    tick("no_retry", 0, 0, 0, 0);
    secs = 8'd0;
    repeat (2) tick("alarm", 1, 32000, 0, 1);
    sec_tick = 1'b1;
    tick("alarm_t1", 1, 32000, 0, 1);
    sec_tick = 1'b1;
    tick("alarm_t2", 0, 0, 0, 0);
    repeat (2) tick("done", 0, 0, 0, 0);
    secs = 8'd9;
    tick("rearm", 0, 0, 0, 0);
    sec_tick = 1'b1;
    repeat (4) tick("beep9", 1, 24000, 0, 0);
    tick("beep9_end", 0, 0, 0, 0);
    secs = 8'd0;
    tick("alarm2", 1, 32000, 0, 1);
    click_req = 1'b1;
    tick("alarm_click", 1, 32000, 0, 1);
    alarm_stop = 1'b1;
    tick("stop", 0, 0, 0, 0);
    alarm_stop = 1'b0;
    tick("stop_done", 0, 0, 0, 0);
    click_req = 1'b1;
    tick("done_ack", 1, 12000, 1, 0);
    tick("done_click", 1, 12000, 0, 0);
    tick("done_back", 0, 0, 0, 0);
    enable = 1'b0;
    tick("disable", 0, 0, 0, 0);
    enable = 1'b1; secs = 8'd20; sec_tick = 1'b1;
    tick("beep20", 1, 19200, 0, 0);
    enable = 1'b0;
    tick("pause", 0, 0, 0, 0);
    enable = 1'b1; sec_tick = 1'b1;
    tick("beep20b", 1, 19200, 0, 0);
    #2 reset = 1'b0;
    #1 check("async_rst", {tone_en, tone_div, click_ack, alarm_active}, 19'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick("post_rst", 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
